// File: rtl/sdram_sched_pkg.sv
// sdram_sched_pkg: shared encodings and default bank bases for the ping-pong SDRAM scheduler.
package sdram_sched_pkg;
   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] WR_ISSUE   = 3'd1;
   localparam logic [2:0] WR_RELEASE = 3'd2;
   localparam logic [2:0] RD_ISSUE   = 3'd3;
   localparam logic [2:0] RD_RELEASE = 3'd4;
   localparam logic GNT_WR = 1'b0;
   localparam logic GNT_RD = 1'b1;
   localparam logic [15:0] BANK0_BASE_DEF = 16'h0000;
   localparam logic [15:0] BANK1_BASE_DEF = 16'h8000;
endpackage

// File: rtl/sdram_rr_arb2.sv
// sdram_rr_arb2: two-way round-robin arbiter; ties go to the side opposite the last grant.
module sdram_rr_arb2
   import sdram_sched_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req_wr,
   input  logic req_rd,
   output logic gnt,
   output logic valid
);
   logic last;
   always_comb begin
      valid = req_wr | req_rd;
      gnt = (req_wr & req_rd) ? ~last : req_rd;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last <= GNT_RD;
      else if (en && valid) last <= gnt;
endmodule

// File: rtl/sdram_pp_sched.sv
// sdram_pp_sched: ping-pong bank scheduler sharing one SDRAM sequencer between a writer and a reader.
module sdram_pp_sched
   import sdram_sched_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter logic [ADDR_W-1:0] BANK0_BASE = ADDR_W'(BANK0_BASE_DEF),
   parameter logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(BANK1_BASE_DEF),
   parameter logic [15:0] BLK_LEN = 16'd512,
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic              clk,
   input  logic              nRST,
   input  logic              wr_req,
   output logic              wr_ack,
   input  logic              rd_req,
   output logic              rd_ack,
   input  logic              flush,
   output logic              seq_wr,
   output logic              seq_rd,
   output logic [ADDR_W-1:0] addr_begin,
   output logic [ADDR_W-1:0] addr_end,
   input  logic              seq_done,
   output logic [1:0]        bank_full,
   output logic              cur_bank,
   output logic              wr_stall,
   output logic              err
);
   localparam logic [ADDR_W-1:0] END0 = ADDR_W'(BANK0_BASE + BLK_LEN - 1);
   localparam logic [ADDR_W-1:0] END1 = ADDR_W'(BANK1_BASE + BLK_LEN - 1);
   logic [2:0] state;
   logic [15:0] timer;
   logic wr_ptr, rd_ptr, gnt, gnt_v, sel, tmo;
   sdram_rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (nRST),
      .en     (state == IDLE && !flush),
      .req_wr (wr_req & ~bank_full[wr_ptr]),
      .req_rd (rd_req & bank_full[rd_ptr]),
      .gnt    (gnt),
      .valid  (gnt_v)
   );
   assign sel = gnt ? rd_ptr : wr_ptr;
   assign tmo = timer == TIMEOUT - 16'd1;
   always_ff @(posedge clk or negedge nRST)
      if (!nRST) begin
         state <= IDLE;
         timer <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         seq_wr <= 1'b0;
         seq_rd <= 1'b0;
         addr_begin <= '0;
         addr_end <= '0;
         wr_ack <= 1'b0;
         rd_ack <= 1'b0;
         bank_full <= 2'b00;
         cur_bank <= 1'b0;
         wr_stall <= 1'b0;
         err <= 1'b0;
      end else begin
         wr_ack <= 1'b0;
         rd_ack <= 1'b0;
         wr_stall <= wr_req & bank_full[wr_ptr];
         timer <= timer + 16'd1;
         // a stuck sequencer abandons the window without touching bank state
         if (state != IDLE && tmo) begin
            seq_wr <= 1'b0;
            seq_rd <= 1'b0;
            err <= 1'b1;
            state <= IDLE;
         end else
            case (state)
               IDLE:
                  if (flush) begin
                     bank_full <= 2'b00;
                     wr_ptr <= 1'b0;
                     rd_ptr <= 1'b0;
                  end else if (gnt_v) begin
                     addr_begin <= sel ? BANK1_BASE : BANK0_BASE;
                     addr_end <= sel ? END1 : END0;
                     cur_bank <= sel;
                     seq_wr <= gnt == GNT_WR;
                     seq_rd <= gnt == GNT_RD;
                     timer <= '0;
                     state <= gnt == GNT_RD ? RD_ISSUE : WR_ISSUE;
                  end
               WR_ISSUE:
                  if (seq_done) begin
                     seq_wr <= 1'b0;
                     bank_full[wr_ptr] <= 1'b1;
                     wr_ptr <= ~wr_ptr;
                     state <= WR_RELEASE;
                  end
               WR_RELEASE:
                  if (!seq_done) begin
                     wr_ack <= 1'b1;
                     state <= IDLE;
                  end
               RD_ISSUE:
                  if (seq_done) begin
                     seq_rd <= 1'b0;
                     bank_full[rd_ptr] <= 1'b0;
                     rd_ptr <= ~rd_ptr;
                     state <= RD_RELEASE;
                  end
               RD_RELEASE:
                  if (!seq_done) begin
                     rd_ack <= 1'b1;
                     state <= IDLE;
                  end
               default: state <= IDLE;
            endcase
      end
endmodule
